// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: STAGES slices of WIDTH/STAGES bits, carry registered between slices.
// Optional macro CLA_PIPE_SATURATE_EN clamps the result to signed max/min on overflow.
module cla_pipe_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int SW = WIDTH / STAGES;
   localparam int NG = (SW >= 4) ? SW / 4 : 1;

   if ((STAGES < 1) || (STAGES > 4) || ((WIDTH % (4 * STAGES)) != 0)) begin : g_param_chk
      $error("cla_pipe_addsub: WIDTH must be a multiple of 4*STAGES and STAGES in 1..4");
   end

   // Handshake: a beat moves on any rising edge where valid && ready; ready never depends on valid.
   // Each slice is 4-bit CLA groups; group carries are flat sum-of-products of group G/P terms.
   function automatic logic [SW:0] cla_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                           input logic ci);
      logic [SW-1:0] g, p, r;
      logic [NG-1:0] gg, gp;
      logic [NG:0]   gc;
      logic          term, cb;
      g  = x & y;
      p  = x ^ y;
      r  = '0;
      gg = '0;
      gp = '0;
      gc = '0;
      for (int k = 0; k < NG; k++) begin
         gp[k] = &p[4*k +: 4];
         for (int j = 0; j < 4; j++) begin
            term = g[4*k+j];
            for (int m = j + 1; m < 4; m++) term = term & p[4*k+m];
            gg[k] = gg[k] | term;
         end
      end
      gc[0] = ci;
      for (int k = 0; k < NG; k++) begin
         term = ci;
         for (int m = 0; m <= k; m++) term = term & gp[m];
         gc[k+1] = term;
         for (int j = 0; j <= k; j++) begin
            term = gg[j];
            for (int m = j + 1; m <= k; m++) term = term & gp[m];
            gc[k+1] = gc[k+1] | term;
         end
      end
      for (int k = 0; k < NG; k++) begin
         for (int i = 0; i < 4; i++) begin
            cb = gc[k];
            for (int m = 0; m < i; m++) cb = cb & p[4*k+m];
            for (int j = 0; j < i; j++) begin
               term = g[4*k+j];
               for (int m = j + 1; m < i; m++) term = term & p[4*k+m];
               cb = cb | term;
            end
            r[4*k+i] = p[4*k+i] ^ cb;
         end
      end
      return {gc[NG], r};
   endfunction

   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] c_q;
   logic [STAGES:0]   adv;
   logic              ovf_q;
   logic              zero_q;
   logic [WIDTH-1:0]  b_eff;
   logic              cin_eff;

   assign b_eff       = sub ? ~b : b;
   assign cin_eff     = carry_in ^ sub;
   assign adv[STAGES] = !v_q[STAGES-1] || out_ready;
   assign in_ready    = adv[0];

   assign out_valid = v_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign carry_out = c_q[STAGES-1];
   assign overflow  = ovf_q;
   assign zero      = zero_q;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic [WIDTH-1:0] src_a, src_b, src_sum, sum_d, fin_d;
      logic             src_v, src_c;
      logic [SW:0]      slice_r;

      if (s == 0) begin : g_head
         assign src_a   = a;
         assign src_b   = b_eff;
         assign src_sum = '0;
         assign src_c   = cin_eff;
         assign src_v   = in_valid;
      end else begin : g_body
         assign src_a   = a_q[s-1];
         assign src_b   = b_q[s-1];
         assign src_sum = sum_q[s-1];
         assign src_c   = c_q[s-1];
         assign src_v   = v_q[s-1];
      end

      assign adv[s]  = !v_q[s] || adv[s+1];
      assign slice_r = cla_add(src_a[s*SW +: SW], src_b[s*SW +: SW], src_c);

      always_comb begin
         sum_d              = src_sum;
         sum_d[s*SW +: SW]  = slice_r[SW-1:0];
      end

      if (s == STAGES - 1) begin : g_tail
         logic ovf_d;
         assign ovf_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum_d[WIDTH-1] != src_a[WIDTH-1]);
`ifdef CLA_PIPE_SATURATE_EN
         // Operand sign tells the overflow direction: positive operands clamp high, negative clamp low.
         assign fin_d = !ovf_d ? sum_d :
                        (src_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
         assign fin_d = sum_d;
`endif
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (adv[s] && src_v) begin
               ovf_q  <= ovf_d;
               zero_q <= (fin_d == '0);
            end
         end
      end else begin : g_mid
         assign fin_d = sum_d;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q[s]   <= 1'b0;
            c_q[s]   <= 1'b0;
            a_q[s]   <= '0;
            b_q[s]   <= '0;
            sum_q[s] <= '0;
         end else if (adv[s]) begin
            v_q[s] <= src_v;
            if (src_v) begin
               c_q[s]   <= slice_r[SW];
               a_q[s]   <= src_a;
               b_q[s]   <= src_b;
               sum_q[s] <= fin_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub (WIDTH=32, STAGES=2): directed vectors, stall, async reset and random soak
// against a signed/unsigned arithmetic model; honours CLA_PIPE_SATURATE_EN.
module tb_cla_pipe_addsub;
   localparam int W  = 32;
   localparam int ST = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         carry_in = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         overflow;
   logic         zero;

   logic [W+2:0] exp_q[$];
   int           check_cnt = 0;
   int           pass_cnt  = 0;
   int           emit_cnt  = 0;
   bit           rand_ready_en = 1'b0;

   cla_pipe_addsub #(.WIDTH(W), .STAGES(ST)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .carry_in(carry_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      check_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
   endtask

   // Reference: true integer results; carry = no unsigned wrap (add) / no borrow (sub).
   function automatic logic [W+2:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic sv, input logic cv);
      longint sa, sb, sr, ua, ub, ur, ci;
      logic [W-1:0] r;
      logic co, ov;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      ua = longint'(av);
      ub = longint'(bv);
      ci = cv ? 64'sd1 : 64'sd0;
      sr = sv ? (sa - sb - ci) : (sa + sb + ci);
      ur = sv ? (ua - ub - ci) : (ua + ub + ci);
      co = sv ? (ur >= 0) : (ur >= 64'sd4294967296);
      ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      r  = ur[W-1:0];
`ifdef CLA_PIPE_SATURATE_EN
      if (ov) r = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
      return {r, co, ov, (r == '0)};
   endfunction

   // driver: called at posedge+1, returns at posedge+1 after the beat is accepted
   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input logic cv);
      int budget;
      budget   = 0;
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      sub      = sv;
      carry_in = cv;
      @(negedge clk);
      while (!in_ready && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end else begin
         exp_q.push_back(model(av, bv, sv, cv));
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         a        = $urandom;
         b        = $urandom;
         sub      = 1'($urandom_range(0, 1));
         carry_in = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 300) begin
         @(posedge clk);
         budget++;
      end
      #1;
      chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h0000_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // random backpressure
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready_en) out_ready = ($urandom_range(0, 9) < 7);
      end
   end

   // scoreboard monitor: samples mid-cycle; a transfer happens on the following rising edge
   initial begin
      logic          prev_stalled;
      logic [W+3:0]  prev_out;
      logic [W+2:0]  exp_v;
      prev_stalled = 1'b0;
      prev_out     = '0;
      forever begin
         @(negedge clk);
         if (prev_stalled && !rst)
            chk("stall_hold", {28'd0, out_valid, sum, carry_out, overflow, zero}, {28'd0, prev_out});
         if (out_valid && out_ready && !rst) begin
            emit_cnt++;
            if (exp_q.size() == 0) chk("unexpected_output", {63'd0, out_valid}, 64'd0);
            else begin
               exp_v = exp_q.pop_front();
               chk("result", {29'd0, sum, carry_out, overflow, zero}, {29'd0, exp_v});
            end
         end
         prev_stalled = out_valid && !out_ready;
         prev_out     = {out_valid, sum, carry_out, overflow, zero};
      end
   end

   // stimulus sequence
   initial begin
      int saved_emit;
      int gap;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_sum", {32'd0, sum}, 64'd0);
      chk("reset_flags", {61'd0, carry_out, overflow, zero}, 64'd0);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;

      // 0xFFFFFFFF + 1 with latency probe
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      chk("latency_early", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("latency_due", {63'd0, out_valid}, 64'd1);
      drain();

      send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
      send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0);
      send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
      send(32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1);
      send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
      drain();

      // back-to-back beats into a stalled output
      out_ready = 1'b0;
      fork
         begin
            for (int i = 1; i <= 4; i++) send(32'(i), 32'(i), 1'b0, 1'b0);
         end
         begin
            repeat (4) @(posedge clk);
            #2;
            chk("stall_in_ready_low", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_head_sum", {32'd0, sum}, 64'd2);
            out_ready = 1'b1;
         end
      join
      drain();

      // async reset with two beats in flight
      send(32'd10, 32'd20, 1'b0, 1'b0);
      send(32'd30, 32'd40, 1'b0, 1'b0);
      chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_reset_valid", {63'd0, out_valid}, 64'd0);
      chk("async_reset_sum", {32'd0, sum}, 64'd0);
      exp_q.delete();
      saved_emit = emit_cnt;
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("no_emit_after_reset", 64'(emit_cnt), 64'(saved_emit));
      chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

      // random soak with random backpressure
      rand_ready_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
      drain();
      rand_ready_en = 1'b0;
      out_ready     = 1'b1;
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
